// File: rtl/dp_vec_loader.sv
// Operand-vector loader for the 4D dot-product unit: gathers up to four (a,b) beats
// into lanes, zero-fills short vectors and hands them downstream via valid/ready.
module dp_vec_loader #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_a0,
  output logic [WIDTH-1:0] data_a1,
  output logic [WIDTH-1:0] data_a2,
  output logic [WIDTH-1:0] data_a3,
  output logic [WIDTH-1:0] data_b0,
  output logic [WIDTH-1:0] data_b1,
  output logic [WIDTH-1:0] data_b2,
  output logic [WIDTH-1:0] data_b3,
  output logic [1:0]       lane_idx,
  output logic [CNT_W-1:0] vec_cnt
);

  typedef enum logic {FILL, HOLD} state_e;

  state_e           state_q, state_d;
  logic [1:0]       lane_idx_q, lane_idx_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [WIDTH-1:0] a_q [4];
  logic [WIDTH-1:0] a_d [4];
  logic [WIDTH-1:0] b_q [4];
  logic [WIDTH-1:0] b_d [4];
  logic             accept;
  logic             handoff;

  assign out_valid = (state_q == HOLD);
  assign in_ready  = (state_q == FILL) || out_ready;
  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    lane_idx_d = lane_idx_q;
    vec_cnt_d  = vec_cnt_q;
    a_d        = a_q;
    b_d        = b_q;

    // A hand-off drops back to FILL first; a same-cycle accept (only possible with
    // lane_idx==0) then proceeds exactly like a lane-0 beat in FILL.
    if (handoff) begin
      vec_cnt_d = vec_cnt_q + CNT_W'(1);
      state_d   = FILL;
    end

    if (accept) begin
      if (lane_idx_q == 2'd0) begin
        a_d[1] = '0;
        a_d[2] = '0;
        a_d[3] = '0;
        b_d[1] = '0;
        b_d[2] = '0;
        b_d[3] = '0;
      end
      a_d[lane_idx_q] = in_a;
      b_d[lane_idx_q] = in_b;
      if ((lane_idx_q == 2'd3) || in_last) begin
        state_d    = HOLD;
        lane_idx_d = '0;
      end else begin
        lane_idx_d = lane_idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      lane_idx_q <= '0;
      vec_cnt_q  <= '0;
      a_q        <= '{default: '0};
      b_q        <= '{default: '0};
    end else begin
      state_q    <= state_d;
      lane_idx_q <= lane_idx_d;
      vec_cnt_q  <= vec_cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
    end
  end

  assign data_a0  = a_q[0];
  assign data_a1  = a_q[1];
  assign data_a2  = a_q[2];
  assign data_a3  = a_q[3];
  assign data_b0  = b_q[0];
  assign data_b1  = b_q[1];
  assign data_b2  = b_q[2];
  assign data_b3  = b_q[3];
  assign lane_idx = lane_idx_q;
  assign vec_cnt  = vec_cnt_q;

endmodule

// File: tb/tb_dp_vec_loader.sv
// Self-checking bench for dp_vec_loader: behavioural vector model compared every
// cycle, directed scenarios with literal expectations, random traffic, counter wrap.
module tb_dp_vec_loader;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] data_a0, data_a1, data_a2, data_a3;
  logic [WIDTH-1:0] data_b0, data_b1, data_b2, data_b3;
  logic [1:0]       lane_idx;
  logic [CNT_W-1:0] vec_cnt;

  int checks = 0;
  int errors = 0;

  dp_vec_loader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_a0(data_a0), .data_a1(data_a1), .data_a2(data_a2), .data_a3(data_a3),
    .data_b0(data_b0), .data_b1(data_b1), .data_b2(data_b2), .data_b3(data_b3),
    .lane_idx(lane_idx), .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: the vector being shown, how many beats of the current
  // vector are in, whether a finished vector awaits the consumer, hand-off count.
  logic [WIDTH-1:0] m_a [4];
  logic [WIDTH-1:0] m_b [4];
  int               m_len;
  bit               m_hold;
  int unsigned      m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_a[i] = '0;
        m_b[i] = '0;
      end
      m_len  = 0;
      m_hold = 1'b0;
      m_cnt  = 0;
    end else begin
      bit acc;
      acc = in_valid && (!m_hold || out_ready);
      if (m_hold && out_ready) begin
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        m_hold = 1'b0;
      end
      if (acc) begin
        if (m_len == 0) begin
          for (int i = 0; i < 4; i++) begin
            m_a[i] = '0;
            m_b[i] = '0;
          end
        end
        m_a[m_len] = in_a;
        m_b[m_len] = in_b;
        if (m_len == 3 || in_last) begin
          m_hold = 1'b1;
          m_len  = 0;
        end else begin
          m_len = m_len + 1;
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    cmp("in_ready",  64'(in_ready),  64'(!m_hold || out_ready));
    cmp("out_valid", 64'(out_valid), 64'(m_hold));
    cmp("lane_idx",  64'(lane_idx),  64'(m_len));
    cmp("vec_cnt",   64'(vec_cnt),   64'(m_cnt));
    cmp("data_a0", 64'(data_a0), 64'(m_a[0]));
    cmp("data_a1", 64'(data_a1), 64'(m_a[1]));
    cmp("data_a2", 64'(data_a2), 64'(m_a[2]));
    cmp("data_a3", 64'(data_a3), 64'(m_a[3]));
    cmp("data_b0", 64'(data_b0), 64'(m_b[0]));
    cmp("data_b1", 64'(data_b1), 64'(m_b[1]));
    cmp("data_b2", 64'(data_b2), 64'(m_b[2]));
    cmp("data_b3", 64'(data_b3), 64'(m_b[3]));
  end

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic last);
    bit ok;
    bit done;
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    done     = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      #1;
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) done = 1'b1;
    end
    if (!done) begin
      errors++;
      $display("FAIL beat_timeout at %0t: got no accept expected accept within 50 cycles", $time);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CNT_W-1:0] ones;
    int guard;

    repeat (3) @(negedge clk);
    cmp("rst_out_valid", 64'(out_valid), 64'd0);
    cmp("rst_lane_idx",  64'(lane_idx),  64'd0);
    cmp("rst_vec_cnt",   64'(vec_cnt),   64'd0);
    cmp("rst_data_a0",   64'(data_a0),   64'd0);
    #1 rst_n = 1'b1;

    // Four-element vector, no stalls.
    out_ready = 1'b1;
    beat(32'h3F800000, 32'h3F800000, 1'b0);
    beat(32'h40000000, 32'h3F800000, 1'b0);
    beat(32'h40400000, 32'h3F800000, 1'b0);
    beat(32'h40800000, 32'h3F800000, 1'b0);
    in_valid = 1'b0;
    cmp("t1_out_valid", 64'(out_valid), 64'd1);
    cmp("t1_a0", 64'(data_a0), 64'h3F800000);
    cmp("t1_a1", 64'(data_a1), 64'h40000000);
    cmp("t1_a2", 64'(data_a2), 64'h40400000);
    cmp("t1_a3", 64'(data_a3), 64'h40800000);
    cmp("t1_b3", 64'(data_b3), 64'h3F800000);
    @(posedge clk); #1;
    cmp("t1_vec_cnt", 64'(vec_cnt), 64'd1);
    cmp("t1_out_valid_drop", 64'(out_valid), 64'd0);

    // All-ones vector followed by a short two-element vector.
    for (int i = 0; i < 4; i++) beat('1, '1, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    beat(32'h11111111, 32'h22222222, 1'b0);
    beat(32'h33333333, 32'h44444444, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'h55555555;
    in_b      = 32'h66666666;
    in_last   = 1'b0;
    cmp("t2_a0", 64'(data_a0), 64'h11111111);
    cmp("t2_a1", 64'(data_a1), 64'h33333333);
    cmp("t2_b1", 64'(data_b1), 64'h44444444);
    cmp("t2_a2", 64'(data_a2), 64'h0);
    cmp("t2_a3", 64'(data_a3), 64'h0);
    cmp("t2_b2", 64'(data_b2), 64'h0);
    cmp("t2_b3", 64'(data_b3), 64'h0);

    // Consumer stalls five cycles while a beat waits.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmp("t3_in_ready", 64'(in_ready), 64'd0);
      cmp("t3_lane_idx", 64'(lane_idx), 64'd0);
      cmp("t3_a0_hold",  64'(data_a0),  64'h11111111);
      cmp("t3_valid",    64'(out_valid), 64'd1);
    end
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    cmp("t3_a0_new",   64'(data_a0),  64'h55555555);
    cmp("t3_a1_clr",   64'(data_a1),  64'h0);
    cmp("t3_lane_idx1", 64'(lane_idx), 64'd1);
    cmp("t3_valid_lo", 64'(out_valid), 64'd0);
    cmp("t3_vec_cnt",  64'(vec_cnt),  64'd3);
    beat(32'h77777777, 32'h88888888, 1'b1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    cmp("t3_vec_cnt4", 64'(vec_cnt), 64'd4);

    // Back-to-back one-element vectors.
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_a = $urandom;
      in_b = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk); #1;
    cmp("t4_vec_cnt", 64'(vec_cnt), 64'd24);

    // Reset in the middle of a vector.
    beat(32'hAAAA0001, 32'hBBBB0001, 1'b0);
    beat(32'hAAAA0002, 32'hBBBB0002, 1'b0);
    beat(32'hAAAA0003, 32'hBBBB0003, 1'b0);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    cmp("t5_out_valid", 64'(out_valid), 64'd0);
    cmp("t5_lane_idx",  64'(lane_idx),  64'd0);
    cmp("t5_vec_cnt",   64'(vec_cnt),   64'd0);
    cmp("t5_a0",        64'(data_a0),   64'd0);
    cmp("t5_b2",        64'(data_b2),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(32'hC0000001, 32'hD0000001, 1'b0);
    beat(32'hC0000002, 32'hD0000002, 1'b0);
    beat(32'hC0000003, 32'hD0000003, 1'b0);
    beat(32'hC0000004, 32'hD0000004, 1'b0);
    in_valid = 1'b0;
    cmp("t5_clean_a0", 64'(data_a0), 64'hC0000001);
    cmp("t5_clean_a3", 64'(data_a3), 64'hC0000004);
    cmp("t5_clean_b2", 64'(data_b2), 64'hD0000003);
    cmp("t5_clean_valid", 64'(out_valid), 64'd1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 3) == 0);
      in_a      = $urandom;
      in_b      = $urandom;
    end

    // Counter wrap via continuous one-element vectors.
    @(negedge clk);
    #1;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    out_ready = 1'b1;
    guard     = 0;
    while (m_cnt != 32'hFFFF && guard < 70000) begin
      in_a = $urandom;
      in_b = $urandom;
      @(posedge clk); #1;
      guard++;
    end
    ones = '1;
    cmp("t6_vec_cnt_max", 64'(vec_cnt), 64'(ones));
    @(posedge clk); #1;
    cmp("t6_vec_cnt_wrap", 64'(vec_cnt), 64'd0);
    cmp("t6_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_vec_loader.md
Name: dp_vec_loader

Overview:
- Input-side assembly stage of the 4D dot-product unit, directly upstream of pipeline stage one.
- Accepts one operand pair (a_i, b_i) per beat over a valid/ready interface.
- Collects up to four pairs into lanes 0..3 and presents the complete vector as data_a0..a3 / data_b0..b3 with an output valid/ready handshake.
- Short vectors, terminated early by in_last, are zero-filled. +0.0 lanes do not perturb the dot product in any precision mode.

Parameters:
- WIDTH, 32, bit width of each operand lane (packed FP word, precision-agnostic).
- CNT_W, 16, width of the completed-vector counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand pair on in_a/in_b is valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_a  input  WIDTH  vector-A element for the current lane.
- in_b  input  WIDTH  vector-B element for the current lane.
- in_last  input  1  this beat is the final element of the vector.
- out_valid  output  1  data_a0..b3 hold a complete vector.
- out_ready  input  1  downstream stage takes the vector.
- data_a0, data_a1, data_a2, data_a3  output  WIDTH each  vector-A lanes 0..3.
- data_b0, data_b1, data_b2, data_b3  output  WIDTH each  vector-B lanes 0..3.
- lane_idx  output  2  lane the next accepted beat will write.
- vec_cnt  output  CNT_W  number of vectors handed off; wraps modulo 2^CNT_W.

Behaviour:
- Single clock domain; rst_n is asynchronous, active-low. Assertion at any time, including mid-vector or while holding, clears everything immediately with no handshake.
- Reset values: state FILL; lane_idx 0; out_valid 0; vec_cnt 0; all data_a*/data_b* 0; partial vector discarded.
- States:
  - FILL: gathering lanes.
  - HOLD: complete vector presented, waiting for the consumer.
- in_ready:
  - FILL: 1.
  - HOLD: equals out_ready, giving combinational pass-through for back-to-back vectors.
- Accept = in_valid && in_ready. Hand-off = out_valid && out_ready.
- Beat accepted in FILL:
  - Lane lane_idx of data_a/data_b is written with in_a/in_b.
  - When lane_idx==0, lanes 1..3 are cleared to 0 in the same cycle. This provides the zero-fill for short vectors.
  - If lane_idx==3 or in_last==1: go to HOLD, out_valid=1 next cycle, lane_idx returns to 0.
  - Otherwise lane_idx increments.
- in_last on lane 3 is redundant and harmless. There is no way to send a vector longer than 4; a 5th beat starts a new vector.
- HOLD:
  - data_a*/data_b* and out_valid are stable until hand-off.
  - in_valid with out_ready=0 is not accepted (in_ready=0).
- Hand-off in HOLD without a simultaneous accept: out_valid=0, go to FILL, vec_cnt increments.
- Hand-off with a simultaneous accept:
  - vec_cnt increments.
  - The new beat writes lane 0, and lanes 1..3 clear.
  - If in_last=1 (a 1-element vector): stay in HOLD and out_valid stays 1. The consumer sees a new vector on consecutive cycles.
  - Otherwise: go to FILL, out_valid=0, lane_idx=1.
- While in FILL, outputs show the partial vector, but out_valid=0 and they are not to be consumed.
- Latency: the last beat accepted at edge N gives out_valid=1 after edge N. Maximum throughput is one vector per 4 cycles for 4-element vectors and one per cycle for 1-element vectors.
- vec_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- No arithmetic on operand contents; lanes are opaque WIDTH-bit words.

Test Plan:
- Reset then 4 beats with a=0x3F800000,0x40000000,0x40400000,0x40800000 and b=0x3F800000 x4, no stalls:
  - out_valid rises on the cycle after beat 4;
  - data_a0..a3 match in order;
  - vec_cnt=1 after hand-off.
- 2-beat vector (in_last on beat 2), preceded by a 4-beat vector of 0xFFFFFFFF:
  - data_a2, data_a3, data_b2 and data_b3 read 0x00000000;
  - lanes 0/1 hold the new data.
- Hold with out_ready=0 for 5 cycles while in_valid=1:
  - in_ready=0 throughout;
  - outputs and lane_idx are unchanged;
  - releasing out_ready accepts the pending beat into lane 0 on the same edge as the hand-off.
- Continuous 1-element vectors (in_last=1 every beat, out_ready=1):
  - out_valid stays high;
  - data_a0 updates every cycle;
  - lanes 1..3 stay 0;
  - vec_cnt increments each cycle.
- Assert rst_n=0 after 3 beats of a vector, then release:
  - all outputs read 0, lane_idx=0, out_valid=0;
  - the next 4 beats form a clean vector.
- Force vec_cnt to 0xFFFF (or run 65536 vectors): the next hand-off wraps vec_cnt to 0x0000.
